// File: rtl/cu_pkg.sv
// Shared control-unit package: opcode constants, control bundle layout and encoder state.
package cu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } enc_state_t;

  // Class 0..6 follows the opcode table order; 7 marks an illegal bundle.
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  function automatic logic [2:0] ctrl_class(input ctrl_bundle_t c);
    logic [2:0] cls;
    case (c)
      10'b0010000010: cls = 3'd0;
      10'b1111000000: cls = 3'd1;
      10'b1010000011: cls = 3'd2;
      10'b1000100000: cls = 3'd3;
      10'b0000010001: cls = 3'd4;
      10'b0010001000: cls = 3'd5;
      10'b1010000100: cls = 3'd6;
      default:        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [6:0] class_opcode(input logic [2:0] cls);
    logic [6:0] op;
    case (cls)
      3'd0:    op = OP_RTYPE;
      3'd1:    op = OP_LOAD;
      3'd2:    op = OP_IALU;
      3'd3:    op = OP_STORE;
      3'd4:    op = OP_BRANCH;
      3'd5:    op = OP_JAL;
      3'd6:    op = OP_JALR;
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cu_enc_fifo.sv
// DEPTH-entry 7-bit synchronous FIFO with full/empty flags; head reads 0 when empty.
module cu_enc_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [6:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [6:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [6:0]    mem_q [DEPTH];
  logic [6:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cu_ctrl_encoder.sv
// Control-bundle to RV32I opcode encoder with output FIFO and illegal-bundle halt.
// Optional CU_ENC_STATS_EN adds saturating per-class counters read via stat_sel/stat_count.
module cu_ctrl_encoder
  import cu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic             err,
  output logic [9:0]       err_ctrl,
  input  logic             clear_err,
  output logic [CNT_W-1:0] enc_count
`ifdef CU_ENC_STATS_EN
  ,
  input  logic [2:0]       stat_sel,
  output logic [7:0]       stat_count
`endif
);

  localparam logic [CNT_W-1:0] ENC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_bundle_t     ctrl;
  logic [2:0]       ctrl_cls;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  enc_state_t       state_q, state_d;
  logic [9:0]       err_ctrl_q, err_ctrl_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  assign ctrl      = ctrl_bundle_t'(in_ctrl);
  assign ctrl_cls  = ctrl_class(ctrl);
  assign legal     = (ctrl_cls != CLS_ILLEGAL);
  assign in_ready  = (state_q == RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign err       = (state_q == HALT);
  assign err_ctrl  = err_ctrl_q;
  assign enc_count = enc_count_q;

  cu_enc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (class_opcode(ctrl_cls)),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_opcode)
  );

  always_comb begin
    state_d     = state_q;
    err_ctrl_d  = err_ctrl_q;
    enc_count_d = enc_count_q;
    case (state_q)
      RUN: begin
        if (accept && legal) begin
          enc_count_d = enc_count_q + ENC_ONE;
        end else if (accept) begin
          state_d    = HALT;
          err_ctrl_d = in_ctrl;
        end
      end
      HALT: begin
        if (clear_err) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      err_ctrl_q  <= '0;
      enc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      err_ctrl_q  <= err_ctrl_d;
      enc_count_q <= enc_count_d;
    end
  end

`ifdef CU_ENC_STATS_EN
  logic [7:0] stat_q [8];
  logic [7:0] stat_d [8];

  // Illegal accepts land in slot 7 through the same class index.
  always_comb begin
    stat_d = stat_q;
    if (accept && (stat_q[ctrl_cls] != 8'hFF)) begin
      stat_d[ctrl_cls] = stat_q[ctrl_cls] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_count = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_cu_ctrl_encoder.sv
// Self-checking bench for cu_ctrl_encoder: directed table, corner sequences and random traffic.
module tb_cu_ctrl_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic             err;
  logic [9:0]       err_ctrl;
  logic             clear_err;
  logic [CNT_W-1:0] enc_count;
`ifdef CU_ENC_STATS_EN
  logic [2:0]       stat_sel;
  logic [7:0]       stat_count;
`endif

  cu_ctrl_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .err        (err),
    .err_ctrl   (err_ctrl),
    .clear_err  (clear_err),
    .enc_count  (enc_count)
`ifdef CU_ENC_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ctrl;
    logic [6:0] op;
  } vec_t;

  vec_t vecs [7];

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending opcodes plus architectural flags.
  logic [6:0] m_q [$];
  bit         m_halt;
  logic [9:0] m_errc;
  int         m_count;
  int         m_stat [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [9:0] c);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ctrl == c) return i;
    end
    return 7;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_halt  = 0;
    m_errc  = '0;
    m_count = 0;
    for (int i = 0; i < 8; i++) m_stat[i] = 0;
  endtask

  task automatic model_step(input bit iv, input logic [9:0] c, input bit ordy, input bit clr);
    bit rdy;
    int k;
    rdy = !m_halt && (m_q.size() < DEPTH);
    if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
    if (m_halt) begin
      if (clr) m_halt = 0;
    end else if (iv && rdy) begin
      k = lookup(c);
      if (m_stat[k] < 255) m_stat[k]++;
      if (k < 7) begin
        m_q.push_back(vecs[k].op);
        m_count = (m_count + 1) % (1 << CNT_W);
      end else begin
        m_halt = 1;
        m_errc = c;
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", int'(in_ready), int'(!m_halt && m_q.size() < DEPTH));
    chk("out_valid", int'(out_valid), int'(m_q.size() > 0));
    chk("out_opcode", int'(out_opcode), (m_q.size() > 0) ? int'(m_q[0]) : 0);
    chk("err", int'(err), int'(m_halt));
    chk("err_ctrl", int'(err_ctrl), int'(m_errc));
    chk("enc_count", int'(enc_count), m_count);
`ifdef CU_ENC_STATS_EN
    stat_sel = 3'($urandom_range(0, 7));
    #1;
    chk("stat_count", int'(stat_count), m_stat[stat_sel]);
`endif
  endtask

  // Called just after a negedge: drive inputs, advance one edge, check at the next negedge.
  task automatic tick(input bit iv, input logic [9:0] c, input bit ordy, input bit clr);
    in_valid  = iv;
    in_ctrl   = c;
    out_ready = ordy;
    clear_err = clr;
    model_step(iv, c, ordy, clr);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_opcode", int'(out_opcode), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_ctrl", int'(err_ctrl), 0);
    chk("rst_enc_count", int'(enc_count), 0);
  endtask

  initial begin
    logic [9:0] rc;
    vecs[0] = '{10'b0010000010, 7'b0110011};
    vecs[1] = '{10'b1111000000, 7'b0000011};
    vecs[2] = '{10'b1010000011, 7'b0010011};
    vecs[3] = '{10'b1000100000, 7'b0100011};
    vecs[4] = '{10'b0000010001, 7'b1100011};
    vecs[5] = '{10'b0010001000, 7'b1101111};
    vecs[6] = '{10'b1010000100, 7'b1100111};

    rst_n = 0; in_valid = 0; in_ctrl = '0; out_ready = 0; clear_err = 0;
`ifdef CU_ENC_STATS_EN
    stat_sel = '0;
`endif
    model_reset();
    #2;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // All seven legal bundles, drained immediately: each visible one cycle after accept.
    for (int i = 0; i < 7; i++) begin
      tick(1, vecs[i].ctrl, 1, 0);
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_opcode", int'(out_opcode), int'(vecs[i].op));
    end
    tick(0, '0, 1, 0);
    chk("tbl_count", int'(enc_count), 7);

    // Backpressure with a two-entry FIFO.
    tick(1, vecs[0].ctrl, 0, 0);
    tick(1, vecs[1].ctrl, 0, 0);
    chk("bp_full_ready", int'(in_ready), 0);
    tick(1, vecs[2].ctrl, 0, 0);
    chk("bp_head_held", int'(out_opcode), int'(vecs[0].op));
    tick(1, vecs[2].ctrl, 1, 0);
    chk("bp_second", int'(out_opcode), int'(vecs[1].op));
    chk("bp_ready_back", int'(in_ready), 1);
    tick(1, vecs[2].ctrl, 1, 0);
    chk("bp_third", int'(out_opcode), int'(vecs[2].op));
    tick(0, '0, 1, 0);

    // Illegal bundle with one entry queued.
    tick(1, vecs[3].ctrl, 0, 0);
    tick(1, 10'h3FF, 0, 0);
    chk("ill_err", int'(err), 1);
    chk("ill_err_ctrl", int'(err_ctrl), 'h3FF);
    chk("ill_ready", int'(in_ready), 0);
    chk("ill_queued", int'(out_opcode), int'(vecs[3].op));
    tick(1, vecs[4].ctrl, 1, 0);
    chk("ill_drained", int'(out_valid), 0);
    tick(0, '0, 1, 1);
    chk("clr_err", int'(err), 0);
    chk("clr_ready", int'(in_ready), 1);

    // Illegal with clear_err in RUN still halts.
    tick(1, 10'h001, 1, 1);
    chk("ill_clr_same", int'(err), 1);
    tick(0, '0, 1, 1);

    // Asynchronous reset mid-stream while halted with an entry queued.
    tick(1, vecs[5].ctrl, 0, 0);
    tick(1, 10'h2AA, 0, 0);
    #2 rst_n = 0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick(1, vecs[6].ctrl, 1, 0);
    chk("post_rst_op", int'(out_opcode), int'(vecs[6].op));
    tick(0, '0, 1, 0);

    // 300 back-to-back R-type bundles: counter passes 255, stats saturate.
    for (int i = 0; i < 300; i++) tick(1, vecs[0].ctrl, 1, 0);
    tick(0, '0, 1, 0);
    chk("r300_count", int'(enc_count), 301);
`ifdef CU_ENC_STATS_EN
    stat_sel = 3'd0;
    #1;
    chk("r300_stat", int'(stat_count), 255);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 8) rc = vecs[$urandom_range(0, 6)].ctrl;
      else rc = 10'($urandom);
      tick(($urandom_range(0, 9) < 7), rc, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
